core_switch_ctrl: RTL and testbench

CORE_SWITCH_CTRL -- requirements
Module: core_switch_ctrl

---
 rtl/core_switch_ctrl_pkg.sv | 8 +
 rtl/core_switch_ctrl_if.sv | 11 +
 rtl/core_switch_ctrl_sel_debounce.sv | 36 +++
 rtl/core_switch_ctrl.sv | 74 +++++++
 tb/tb_core_switch_ctrl.sv | 135 +++++++++++++
 5 files changed

// File: rtl/core_switch_ctrl_pkg.sv
// core_switch_ctrl_pkg: shared FSM encoding, reset polarity and default cycle constants
package core_switch_ctrl_pkg;
    localparam logic RstEnable = 1'b1;
    localparam int DB_CYCLES_DEF = 1000000;
    localparam int PRE_CYCLES_DEF = 4;
    localparam int HOLD_CYCLES_DEF = 16;
    typedef enum logic [1:0] {HOLD, RUN, PRE, SWAP} state_t;
endpackage

// File: rtl/core_switch_ctrl_if.sv
// core_switch_ctrl_if: switch-to-SoC signal bundle
// sel_sw_i raw switch; chip_sel_o core select; soc_rst_n_o SoC reset; busy_o not in RUN; switch_cnt_o switch count
interface core_switch_ctrl_if;
    logic sel_sw_i;
    logic chip_sel_o;
    logic soc_rst_n_o;
    logic busy_o;
    logic [7:0] switch_cnt_o;
    modport master(input sel_sw_i, output chip_sel_o, soc_rst_n_o, busy_o, switch_cnt_o);
    modport slave(output sel_sw_i, input chip_sel_o, soc_rst_n_o, busy_o, switch_cnt_o);
endinterface

// File: rtl/core_switch_ctrl_sel_debounce.sv
// sel_debounce: 2-flop synchronizer plus debounce of the raw core-select switch
// clk, rst (async high); raw async switch in; level debounced out
module sel_debounce
    import core_switch_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
    logic sync1, sync2;
    logic [DW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end
endmodule

// File: rtl/core_switch_ctrl.sv
// core_switch_ctrl: sequences SoC reset around core-select switch changes
// clk, rst (async high); bus: sel_sw_i in; chip_sel_o, soc_rst_n_o, busy_o, switch_cnt_o out
module core_switch_ctrl
    import core_switch_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int PRE_CYCLES = PRE_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input logic clk,
    input logic rst,
    core_switch_ctrl_if.master bus
);
    localparam int PW = $clog2(PRE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int CW = PW > HW ? PW : HW;
    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic level;
    sel_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk(clk),
        .rst(rst),
        .raw(bus.sel_sw_i),
        .level(level)
    );
    // Outputs are assigned alongside the state transition so they always match the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state <= HOLD;
            cnt <= '0;
            bus.chip_sel_o <= 1'b0;
            bus.soc_rst_n_o <= 1'b0;
            bus.busy_o <= 1'b1;
            bus.switch_cnt_o <= 8'd0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= RUN;
                        cnt <= '0;
                        bus.soc_rst_n_o <= 1'b1;
                        bus.busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (level != bus.chip_sel_o) begin
                        state <= PRE;
                        bus.soc_rst_n_o <= 1'b0;
                        bus.busy_o <= 1'b1;
                    end
                end
                PRE: begin
                    if (cnt == PRE_LAST) begin
                        state <= SWAP;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SWAP: begin
                    // Level is re-sampled here, so a switch that reverted during PRE leaves the select untouched.
                    bus.chip_sel_o <= level;
                    bus.switch_cnt_o <= bus.switch_cnt_o + ((level != bus.chip_sel_o) ? 8'd1 : 8'd0);
                    state <= HOLD;
                end
                default: state <= HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_core_switch_ctrl.sv
// tb_core_switch_ctrl: directed vector bench for core_switch_ctrl
module tb_core_switch_ctrl;
    logic clk, rst;
    int compared = 0, mismatched = 0;
    core_switch_ctrl_if bus();
    core_switch_ctrl_if bus_f();
    core_switch_ctrl #(.DB_CYCLES(8), .PRE_CYCLES(4), .HOLD_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    // Short debounce instance so a revert can settle before SWAP samples the level.
    core_switch_ctrl #(.DB_CYCLES(2), .PRE_CYCLES(4), .HOLD_CYCLES(16)) dut_f (
        .clk(clk), .rst(rst), .bus(bus_f)
    );
    typedef struct {
        logic sel;
        int n;
        logic chip;
        logic rn;
        logic busy;
        logic [7:0] cnt;
    } vec_t;
    vec_t tbl[11];
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic pulse_check(input string name, input logic exp_chip, input logic [7:0] exp_cnt);
        int n, low;
        n = 0;
        while (bus.soc_rst_n_o && n < 200) begin
            step(1);
            n++;
        end
        check({name, "_fall"}, 32'(bus.soc_rst_n_o), 32'd0);
        low = 0;
        while (!bus.soc_rst_n_o && low < 200) begin
            low++;
            step(1);
        end
        check({name, "_low"}, 32'(low), 32'd21);
        check({name, "_chip"}, 32'(bus.chip_sel_o), 32'(exp_chip));
        check({name, "_cnt"}, 32'(bus.switch_cnt_o), 32'(exp_cnt));
        check({name, "_busy"}, 32'(bus.busy_o), 32'd0);
    endtask
    initial begin
        int n, low;
        tbl[0]  = '{1'b0, 15, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[1]  = '{1'b0, 1,  1'b0, 1'b1, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 5,  1'b0, 1'b1, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 20, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 10, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1,  1'b0, 1'b0, 1'b1, 8'd0};
        tbl[6]  = '{1'b1, 4,  1'b0, 1'b0, 1'b1, 8'd0};
        tbl[7]  = '{1'b1, 1,  1'b1, 1'b0, 1'b1, 8'd1};
        tbl[8]  = '{1'b1, 15, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[9]  = '{1'b1, 1,  1'b1, 1'b1, 1'b0, 8'd1};
        tbl[10] = '{1'b1, 30, 1'b1, 1'b1, 1'b0, 8'd1};
        rst = 1'b1;
        bus.sel_sw_i = 1'b0;
        bus_f.sel_sw_i = 1'b0;
        step(3);
        check("rst_chip", 32'(bus.chip_sel_o), 32'd0);
        check("rst_rn", 32'(bus.soc_rst_n_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd1);
        check("rst_cnt", 32'(bus.switch_cnt_o), 32'd0);
        rst = 1'b0;
        // Power-up, glitch rejection and a clean 0->1 switch, cycle by cycle.
        for (int i = 0; i < 11; i++) begin
            bus.sel_sw_i = tbl[i].sel;
            step(tbl[i].n);
            check($sformatf("vec%0d_chip", i), 32'(bus.chip_sel_o), 32'(tbl[i].chip));
            check($sformatf("vec%0d_rn", i), 32'(bus.soc_rst_n_o), 32'(tbl[i].rn));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy_o), 32'(tbl[i].busy));
            check($sformatf("vec%0d_cnt", i), 32'(bus.switch_cnt_o), 32'(tbl[i].cnt));
        end
        bus.sel_sw_i = 1'b0;
        pulse_check("back_to_0", 1'b0, 8'd2);
        // Revert on the fast instance: raw returns to 0 right after PRE is entered.
        bus_f.sel_sw_i = 1'b1;
        step(5);
        check("revert_fall", 32'(bus_f.soc_rst_n_o), 32'd0);
        bus_f.sel_sw_i = 1'b0;
        low = 1;
        while (!bus_f.soc_rst_n_o && low < 200) begin
            step(1);
            if (!bus_f.soc_rst_n_o) low++;
        end
        check("revert_low", 32'(low), 32'd21);
        check("revert_chip", 32'(bus_f.chip_sel_o), 32'd0);
        check("revert_cnt", 32'(bus_f.switch_cnt_o), 32'd0);
        step(20);
        check("revert_rn_after", 32'(bus_f.soc_rst_n_o), 32'd1);
        check("revert_chip_after", 32'(bus_f.chip_sel_o), 32'd0);
        check("revert_main_rn", 32'(bus.soc_rst_n_o), 32'd1);
        // Reset pulsed during HOLD after a switch to 1.
        bus.sel_sw_i = 1'b1;
        n = 0;
        while (!bus.chip_sel_o && n < 200) begin
            step(1);
            n++;
        end
        check("midrst_reach_hold", 32'(bus.chip_sel_o), 32'd1);
        step(3);
        rst = 1'b1;
        #1;
        check("midrst_chip", 32'(bus.chip_sel_o), 32'd0);
        check("midrst_rn", 32'(bus.soc_rst_n_o), 32'd0);
        check("midrst_busy", 32'(bus.busy_o), 32'd1);
        check("midrst_cnt", 32'(bus.switch_cnt_o), 32'd0);
        step(1);
        rst = 1'b0;
        step(15);
        check("midrst_hold15", 32'(bus.soc_rst_n_o), 32'd0);
        step(1);
        check("midrst_hold16", 32'(bus.soc_rst_n_o), 32'd1);
        pulse_check("midrst_reswitch", 1'b1, 8'd1);
        // Alternate the switch until the counter wraps past 255.
        for (int i = 0; i < 255; i++) begin
            bus.sel_sw_i = ~bus.sel_sw_i;
            pulse_check($sformatf("wrap%0d", i), i[0], 8'((i + 2) & 255));
        end
        check("wrap_zero", 32'(bus.switch_cnt_o), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
